// File: rtl/key_command_parser_if.sv
// Scan-code input and control outputs of the keyboard command parser.
// master drives scan bytes; slave is the parser.
interface key_command_parser_if;
   logic [7:0] scan_code;
   logic       scan_valid;
   logic [9:0] bpm;
   logic [4:0] num_steps;
   logic       bpm_we;
   logic       len_we;
   logic       play_toggle;
   logic       mute;
   logic [1:0] entry_mode;
   logic [9:0] entry_value;

   modport master (
      output scan_code, scan_valid,
      input  bpm, num_steps, bpm_we, len_we,
      input  play_toggle, mute, entry_mode, entry_value
   );

   modport slave (
      input  scan_code, scan_valid,
      output bpm, num_steps, bpm_we, len_we,
      output play_toggle, mute, entry_mode, entry_value
   );
endinterface

// File: rtl/key_command_parser.sv
// Set-2 scan-code parser: filters break/extended codes, runs numeric
// BPM / loop-length entry and emits control values and command pulses.
module key_command_parser #(
   parameter int BPM_DEFAULT   = 120,
   parameter int BPM_MIN       = 30,
   parameter int BPM_MAX       = 300,
   parameter int STEPS_DEFAULT = 16,
   parameter int STEPS_MAX     = 16,
   parameter int DIGITS_MAX    = 3
) (
   input logic CLOCK_50,
   input logic resetn,
   key_command_parser_if.slave bus
);
   localparam int CW = $clog2(DIGITS_MAX + 1);
   localparam logic [9:0] BDEF = 10'(BPM_DEFAULT);
   localparam logic [9:0] BMIN = 10'(BPM_MIN);
   localparam logic [9:0] BMAX = 10'(BPM_MAX);
   localparam logic [4:0] SDEF = 5'(STEPS_DEFAULT);
   localparam logic [9:0] SMAX = 10'(STEPS_MAX);
   localparam logic [CW-1:0] DMAX = CW'(DIGITS_MAX);

   localparam logic [7:0] K_BRK = 8'hF0;
   localparam logic [7:0] K_EXT = 8'hE0;
   localparam logic [7:0] K_B   = 8'h32;
   localparam logic [7:0] K_L   = 8'h4B;
   localparam logic [7:0] K_ENT = 8'h5A;
   localparam logic [7:0] K_SP  = 8'h29;
   localparam logic [7:0] K_M   = 8'h3A;
   localparam logic [7:0] K_ESC = 8'h76;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BPM_ENT = 2'd1,
      LEN_ENT = 2'd2
   } mode_e;

   mode_e         state, state_n;
   logic [9:0]    acc, acc_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [9:0]    bpm_q, bpm_n;
   logic [4:0]    steps_q, steps_n;
   logic          brk_q, brk_n;
   logic          ext_q, ext_n;
   logic          mute_q, mute_n;
   logic          bwe_q, bwe_n;
   logic          lwe_q, lwe_n;
   logic          play_q, play_n;

   logic [7:0] code;
   logic       is_dig;
   logic [3:0] dval;
   logic [9:0] bpm_clamp;
   logic [4:0] steps_clamp;

   assign code = bus.scan_code;

   always_comb begin
      is_dig = 1'b1;
      dval   = 4'd0;
      case (code)
         8'h45:   dval = 4'd0;
         8'h16:   dval = 4'd1;
         8'h1E:   dval = 4'd2;
         8'h26:   dval = 4'd3;
         8'h25:   dval = 4'd4;
         8'h2E:   dval = 4'd5;
         8'h36:   dval = 4'd6;
         8'h3D:   dval = 4'd7;
         8'h3E:   dval = 4'd8;
         8'h46:   dval = 4'd9;
         default: is_dig = 1'b0;
      endcase
   end

   assign bpm_clamp = (acc < BMIN) ? BMIN :
                      (acc > BMAX) ? BMAX : acc;
   assign steps_clamp = (acc == 10'd0) ? 5'd1 :
                        (acc > SMAX) ? 5'(SMAX) : acc[4:0];

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         acc     <= '0;
         cnt     <= '0;
         bpm_q   <= BDEF;
         steps_q <= SDEF;
         brk_q   <= 1'b0;
         ext_q   <= 1'b0;
         mute_q  <= 1'b0;
         bwe_q   <= 1'b0;
         lwe_q   <= 1'b0;
         play_q  <= 1'b0;
      end else begin
         state   <= state_n;
         acc     <= acc_n;
         cnt     <= cnt_n;
         bpm_q   <= bpm_n;
         steps_q <= steps_n;
         brk_q   <= brk_n;
         ext_q   <= ext_n;
         mute_q  <= mute_n;
         bwe_q   <= bwe_n;
         lwe_q   <= lwe_n;
         play_q  <= play_n;
      end
   end

   always_comb begin
      state_n = state;
      acc_n   = acc;
      cnt_n   = cnt;
      bpm_n   = bpm_q;
      steps_n = steps_q;
      brk_n   = brk_q;
      ext_n   = ext_q;
      mute_n  = mute_q;
      bwe_n   = 1'b0;
      lwe_n   = 1'b0;
      play_n  = 1'b0;
      if (bus.scan_valid) begin
         // E0 F0 xx collapses into a plain break so xx is dropped
         if (ext_q) begin
            ext_n = 1'b0;
            if (code == K_BRK) brk_n = 1'b1;
         end else if (brk_q) begin
            brk_n = 1'b0;
         end else if (code == K_BRK) begin
            brk_n = 1'b1;
         end else if (code == K_EXT) begin
            ext_n = 1'b1;
         end else if (state == IDLE) begin
            unique case (1'b1)
               code == K_B: begin
                  state_n = BPM_ENT;
                  acc_n   = '0;
                  cnt_n   = '0;
               end
               code == K_L: begin
                  state_n = LEN_ENT;
                  acc_n   = '0;
                  cnt_n   = '0;
               end
               code == K_SP: play_n = 1'b1;
               code == K_M:  mute_n = ~mute_q;
               default: ;
            endcase
         end else begin
            unique case (1'b1)
               is_dig: begin
                  if (cnt < DMAX) begin
                     acc_n = acc * 10'd10 + {6'd0, dval};
                     cnt_n = cnt + 1'b1;
                  end
               end
               code == K_ENT: begin
                  if (cnt != '0) begin
                     if (state == BPM_ENT) begin
                        bpm_n = bpm_clamp;
                        bwe_n = 1'b1;
                     end else begin
                        steps_n = steps_clamp;
                        lwe_n   = 1'b1;
                     end
                  end
                  state_n = IDLE;
                  acc_n   = '0;
                  cnt_n   = '0;
               end
               code == K_ESC: begin
                  state_n = IDLE;
                  acc_n   = '0;
                  cnt_n   = '0;
               end
               code == K_B: begin
                  state_n = BPM_ENT;
                  acc_n   = '0;
                  cnt_n   = '0;
               end
               code == K_L: begin
                  state_n = LEN_ENT;
                  acc_n   = '0;
                  cnt_n   = '0;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.bpm         = bpm_q;
   assign bus.num_steps   = steps_q;
   assign bus.bpm_we      = bwe_q;
   assign bus.len_we      = lwe_q;
   assign bus.play_toggle = play_q;
   assign bus.mute        = mute_q;
   assign bus.entry_mode  = state;
   assign bus.entry_value = acc;
endmodule

// File: tb/tb_key_command_parser.sv
// Bench for key_command_parser: table of scan bytes with expected
// outputs, checked through a scoreboard one cycle after each strobe.
module tb_key_command_parser;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   key_command_parser_if kif();

   key_command_parser dut (
      .CLOCK_50 (clk),
      .resetn   (rst_n),
      .bus      (kif)
   );

   typedef struct {
      logic [7:0] code;
      logic [9:0] bpm;
      logic [4:0] steps;
      logic [1:0] mode;
      logic [9:0] val;
      logic       mute;
      logic       bwe;
      logic       lwe;
      logic       play;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int errors = 0;
   int checks = 0;

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(logic [7:0] c, int b, int s, int m,
                               int v, bit mu, bit bw, bit lw, bit p);
      vec_t r;
      r.code  = c;
      r.bpm   = 10'(b);
      r.steps = 5'(s);
      r.mode  = 2'(m);
      r.val   = 10'(v);
      r.mute  = mu;
      r.bwe   = bw;
      r.lwe   = lw;
      r.play  = p;
      return r;
   endfunction

   task automatic check_vec(string tag, vec_t e);
      chk({tag, " bpm"},   int'(kif.bpm),         int'(e.bpm));
      chk({tag, " steps"}, int'(kif.num_steps),   int'(e.steps));
      chk({tag, " mode"},  int'(kif.entry_mode),  int'(e.mode));
      chk({tag, " value"}, int'(kif.entry_value), int'(e.val));
      chk({tag, " mute"},  int'(kif.mute),        int'(e.mute));
      chk({tag, " bpm_we"}, int'(kif.bpm_we),     int'(e.bwe));
      chk({tag, " len_we"}, int'(kif.len_we),     int'(e.lwe));
      chk({tag, " play"},  int'(kif.play_toggle), int'(e.play));
   endtask

   // Outputs are sampled 1 time unit after the capturing edge
   always @(posedge clk) begin
      logic was;
      vec_t e;
      was = kif.scan_valid;
      #1;
      if (rst_n && was) begin
         if (sb.size() == 0) begin
            chk("scoreboard_underflow", 1, 0);
         end else begin
            e = sb.pop_front();
            check_vec($sformatf("code_%h", e.code), e);
         end
      end else if (rst_n) begin
         chk("idle_pulses",
             int'({kif.bpm_we, kif.len_we, kif.play_toggle}), 0);
      end
   end

   task automatic send(vec_t v);
      @(negedge clk);
      kif.scan_code  = v.code;
      kif.scan_valid = 1'b1;
      sb.push_back(v);
   endtask

   task automatic gap(int n);
      repeat (n) begin
         @(negedge clk);
         kif.scan_valid = 1'b0;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
      chk("drain", sb.size(), 0);
   endtask

   initial begin
      kif.scan_code  = 8'h00;
      kif.scan_valid = 1'b0;

      //         code   bpm stp md val  mu bw lw pl
      tbl.push_back(mk(8'h32, 120, 16, 1,   0, 0, 0, 0, 0));
      tbl.push_back(mk(8'h46, 120, 16, 1,   9, 0, 0, 0, 0));
      tbl.push_back(mk(8'h46, 120, 16, 1,  99, 0, 0, 0, 0));
      tbl.push_back(mk(8'h46, 120, 16, 1, 999, 0, 0, 0, 0));
      tbl.push_back(mk(8'h5A, 300, 16, 0,   0, 0, 1, 0, 0));
      tbl.push_back(mk(8'h4B, 300, 16, 2,   0, 0, 0, 0, 0));
      tbl.push_back(mk(8'h16, 300, 16, 2,   1, 0, 0, 0, 0));
      tbl.push_back(mk(8'h5A, 300,  1, 0,   0, 0, 0, 1, 0));
      tbl.push_back(mk(8'h3A, 300,  1, 0,   0, 1, 0, 0, 0));
      tbl.push_back(mk(8'h29, 300,  1, 0,   0, 1, 0, 0, 1));
      tbl.push_back(mk(8'hF0, 300,  1, 0,   0, 1, 0, 0, 0));
      tbl.push_back(mk(8'h32, 300,  1, 0,   0, 1, 0, 0, 0));
      tbl.push_back(mk(8'hE0, 300,  1, 0,   0, 1, 0, 0, 0));
      tbl.push_back(mk(8'h29, 300,  1, 0,   0, 1, 0, 0, 0));
      tbl.push_back(mk(8'hE0, 300,  1, 0,   0, 1, 0, 0, 0));
      tbl.push_back(mk(8'hF0, 300,  1, 0,   0, 1, 0, 0, 0));
      tbl.push_back(mk(8'h29, 300,  1, 0,   0, 1, 0, 0, 0));
      tbl.push_back(mk(8'h29, 300,  1, 0,   0, 1, 0, 0, 1));
      tbl.push_back(mk(8'h32, 300,  1, 1,   0, 1, 0, 0, 0));
      tbl.push_back(mk(8'h16, 300,  1, 1,   1, 1, 0, 0, 0));
      tbl.push_back(mk(8'h1E, 300,  1, 1,  12, 1, 0, 0, 0));
      tbl.push_back(mk(8'h26, 300,  1, 1, 123, 1, 0, 0, 0));
      tbl.push_back(mk(8'h25, 300,  1, 1, 123, 1, 0, 0, 0));
      tbl.push_back(mk(8'h5A, 123,  1, 0,   0, 1, 1, 0, 0));
      tbl.push_back(mk(8'h32, 123,  1, 1,   0, 1, 0, 0, 0));
      tbl.push_back(mk(8'h16, 123,  1, 1,   1, 1, 0, 0, 0));
      tbl.push_back(mk(8'h4B, 123,  1, 2,   0, 1, 0, 0, 0));
      tbl.push_back(mk(8'h1E, 123,  1, 2,   2, 1, 0, 0, 0));
      tbl.push_back(mk(8'h5A, 123,  2, 0,   0, 1, 0, 1, 0));
      tbl.push_back(mk(8'h32, 123,  2, 1,   0, 1, 0, 0, 0));
      tbl.push_back(mk(8'h46, 123,  2, 1,   9, 1, 0, 0, 0));
      tbl.push_back(mk(8'h76, 123,  2, 0,   0, 1, 0, 0, 0));
      tbl.push_back(mk(8'h32, 123,  2, 1,   0, 1, 0, 0, 0));
      tbl.push_back(mk(8'h5A, 123,  2, 0,   0, 1, 0, 0, 0));
      tbl.push_back(mk(8'h32, 123,  2, 1,   0, 1, 0, 0, 0));
      tbl.push_back(mk(8'h29, 123,  2, 1,   0, 1, 0, 0, 0));
      tbl.push_back(mk(8'h3A, 123,  2, 1,   0, 1, 0, 0, 0));
      tbl.push_back(mk(8'h76, 123,  2, 0,   0, 1, 0, 0, 0));
      tbl.push_back(mk(8'h32, 123,  2, 1,   0, 1, 0, 0, 0));
      tbl.push_back(mk(8'h16, 123,  2, 1,   1, 1, 0, 0, 0));
      tbl.push_back(mk(8'h45, 123,  2, 1,  10, 1, 0, 0, 0));
      tbl.push_back(mk(8'h5A,  30,  2, 0,   0, 1, 1, 0, 0));

      #12;
      check_vec("reset", mk(8'h00, 120, 16, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      gap(2);

      for (int i = 0; i < tbl.size(); i++) begin
         send(tbl[i]);
         if (i % 7 == 6) gap(1);
      end
      gap(2);
      drain();

      send(mk(8'h32, 30, 2, 1, 0, 1, 0, 0, 0));
      send(mk(8'h46, 30, 2, 1, 9, 1, 0, 0, 0));
      gap(1);
      drain();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_vec("async_reset", mk(8'h00, 120, 16, 0, 0, 0, 0, 0, 0));
      #1;
      rst_n = 1'b1;
      send(mk(8'h5A, 120, 16, 0, 0, 0, 0, 0, 0));
      gap(3);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/key_command_parser.md
Name: key_command_parser

Overview:
- Sits between the PS/2 receiver (or the simulation scan-code injection path) and the step_sequencer control/timing logic.
- Consumes raw set-2 scan-code bytes and discards break and extended sequences.
- Runs a small entry state machine for numeric BPM (`b`) and loop-length (`l`) entry.
- Emits registered control values plus single-cycle command pulses for play/stop (Space) and mute (`m`).

Parameters:
- BPM_DEFAULT, 120, BPM value after reset.
- BPM_MIN, 30, lower clamp applied on BPM commit.
- BPM_MAX, 300, upper clamp applied on BPM commit.
- STEPS_DEFAULT, 16, loop length after reset.
- STEPS_MAX, 16, upper clamp for loop length; lower clamp is fixed at 1.
- DIGITS_MAX, 3, maximum digits accepted per entry; further digits are ignored.

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- scan_code  in  8  scan-code byte; sampled only when scan_valid=1.
- scan_valid  in  1  one-cycle strobe; one byte per strobe.
- bpm  out  10  committed BPM.
- num_steps  out  5  committed loop length, 1..STEPS_MAX.
- bpm_we  out  1  one-cycle pulse when bpm is updated.
- len_we  out  1  one-cycle pulse when num_steps is updated.
- play_toggle  out  1  one-cycle pulse per Space make.
- mute  out  1  mute level; toggled by `m`.
- entry_mode  out  2  0=IDLE, 1=BPM entry, 2=LEN entry; used for HEX/LED display.
- entry_value  out  10  live accumulator, for HEX display during entry.

Behaviour:
- Reset values (asynchronous, while resetn=0):
  - bpm=BPM_DEFAULT, num_steps=STEPS_DEFAULT, mute=0.
  - All pulses 0, entry_mode=0, entry_value=0.
  - break_pending=0, ext_pending=0, digit count=0.
- Reset mid-entry discards the accumulator; no commit pulse is produced.
- Latency: a byte strobed in cycle N affects registered outputs in cycle N+1. Pulses are exactly one cycle wide.
- Prefix handling, evaluated first:
  - 0xF0 sets break_pending. The next strobed byte is dropped and clears break_pending.
  - 0xE0 sets ext_pending. The next byte is dropped unless it is 0xF0; in that case break_pending is set and ext_pending is cleared. This drops E0 F0 xx entirely.
  - Dropped bytes change no other state.
- Make codes are acted on every time they arrive, including typematic repeats. For example, three strobes of 0x46 enter three digits 9.
- Key map:
  - b=0x32, l=0x4B, Enter=0x5A, Space=0x29, m=0x3A, Esc=0x76.
  - Digits: 0=0x45, 1=0x16, 2=0x1E, 3=0x26, 4=0x25, 5=0x2E, 6=0x36, 7=0x3D, 8=0x3E, 9=0x46.
  - All other codes are ignored.
- IDLE state:
  - b → BPM entry, with accumulator=0 and count=0.
  - l → LEN entry, with accumulator=0 and count=0.
  - Space → play_toggle pulse.
  - m → mute inverts.
  - Digits, Enter and Esc are ignored.
- BPM entry / LEN entry states:
  - Digit with count<DIGITS_MAX → accumulator = accumulator*10 + d, count+1. The maximum accumulator value is 999, which fits in 10 bits.
  - Digit with count=DIGITS_MAX → ignored.
  - Enter with count>0 → commit and return to IDLE.
    - BPM entry: bpm = clamp(acc, BPM_MIN, BPM_MAX), and bpm_we pulses.
    - LEN entry: num_steps = clamp(acc, 1, STEPS_MAX), and len_we pulses.
  - Enter with count=0 → return to IDLE with no pulse.
  - Esc → return to IDLE with no commit.
  - b or l → restart entry in the named mode with the accumulator cleared.
  - Space and m are ignored; there is no play_toggle or mute change during entry.
- entry_value mirrors the accumulator and reads 0 in IDLE.
- scan_valid=0 → no state change. There are no back-to-back constraints; consecutive-cycle strobes must all be processed.

Test Plan:
- Reset → bpm=120, num_steps=16, mute=0, entry_mode=0, all pulses 0.
- Entry with over-range value and clamps:
  - Sequence: 32,46,46,46,5A → entry_value steps 9,99,999.
  - On the Enter cycle+1: bpm=300 and bpm_we high for one cycle.
  - Then 4B,16,5A → num_steps=1 with one len_we pulse.
  - Then 3A → mute=1.
  - Then 29 → one play_toggle pulse.
- Break and extended filtering:
  - F0,32 → no mode change.
  - E0,29 → no play_toggle.
  - E0,F0,29 → no play_toggle.
  - Following 29 → one play_toggle pulse.
- Digit limit and restart:
  - Sequence: 32,16,1E,26,25,5A → bpm=123 (fourth digit ignored).
  - 32,16,4B,1E,5A → num_steps=2 and bpm unchanged.
- Abort paths and ignored keys during entry:
  - 32,46,76 → IDLE with no bpm_we.
  - 32,5A → no bpm_we.
  - 32,29,3A,76 → no play_toggle and mute unchanged.
  - 32,16,45,5A → bpm=30 (10 clamped up to BPM_MIN).
- Async reset mid-entry:
  - Sequence 32,46, then assert resetn=0 for any sub-cycle interval.
  - Outputs reset immediately; entry_mode=0.
  - After release, 5A produces no pulse.
